// File: rtl/player_buttons.sv
// player_buttons: synchronise, debounce and arbitrate the left/right keys into clean movement levels
module player_buttons #(
  parameter int DEBOUNCE_MS = 20,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic clk_1ms,
  input  logic reset,
  input  logic key_left,
  input  logic key_right,
  output logic button,
  output logic button1,
  output logic locked
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam logic [1:0] LOCK  = 2'd3;
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_MS - 1);
  localparam logic [1:0] RELEASED = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d, press;
  logic [1:0]      db_q, db_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic            button_q, button_d, button1_q, button1_d, locked_q, locked_d;
  always_comb begin
    sync1_d = {key_right, key_left};
    sync2_d = sync1_q;
    press   = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    for (int k = 0; k < 2; k++) begin
      db_d[k]  = (press[k] != db_q[k] && cnt_q[k] == CNT_MAX) ? press[k] : db_q[k];
      cnt_d[k] = (press[k] == db_q[k] || cnt_q[k] == CNT_MAX) ? 8'd0 : cnt_q[k] + 8'd1;
    end
  end
  // LOCK only clears once both keys are released
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (db_q == 2'b01) ? LEFT : (db_q == 2'b10) ? RIGHT : (db_q == 2'b11) ? LOCK : IDLE;
      LEFT:    state_d = db_q[1] ? (db_q[0] ? LOCK : RIGHT) : (db_q[0] ? LEFT : IDLE);
      RIGHT:   state_d = db_q[0] ? (db_q[1] ? LOCK : LEFT) : (db_q[1] ? RIGHT : IDLE);
      default: state_d = (db_q == 2'b00) ? IDLE : LOCK;
    endcase
    button_d  = state_d == LEFT;
    button1_d = state_d == RIGHT;
    locked_d  = state_d == LOCK;
  end
  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      db_q      <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      button_q  <= 1'b0;
      button1_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      button_q  <= button_d;
      button1_q <= button1_d;
      locked_q  <= locked_d;
    end
  end
  assign button  = button_q;
  assign button1 = button1_q;
  assign locked  = locked_q;
endmodule

// File: tb/tb_player_buttons.sv
// tb_player_buttons: randomized and directed checks of two player_buttons configurations against a window model
module tb_player_buttons;
  logic clk = 1'b0;
  logic rst;
  logic kl0, kr0, kl1, kr1;
  logic b0, b10, lk0, b1, b11, lk1;
  int n_cmp = 0;
  int n_bad = 0;
  int dms [2] = '{20, 1};
  bit al [2] = '{1'b1, 1'b0};
  bit r1 [4];
  bit r2 [4];
  bit db [4];
  bit [31:0] hist [4];
  int ns [4];
  int mode [2];
  always #5 clk = ~clk;
  player_buttons #(.DEBOUNCE_MS(20), .ACTIVE_LOW(1)) u0 (
    .clk_1ms(clk), .reset(rst), .key_left(kl0), .key_right(kr0),
    .button(b0), .button1(b10), .locked(lk0));
  player_buttons #(.DEBOUNCE_MS(1), .ACTIVE_LOW(0)) u1 (
    .clk_1ms(clk), .reset(rst), .key_left(kl1), .key_right(kr1),
    .button(b1), .button1(b11), .locked(lk1));
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // mode: 0 idle, 1 left, 2 right, 3 lock; a level is accepted once the last D pressed samples all disagree with it
  task automatic model_step();
    bit raw [4];
    bit l, r, p;
    bit [31:0] mask;
    raw[0] = kl0; raw[1] = kr0; raw[2] = kl1; raw[3] = kr1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mode[i] = 0;
        for (int c = 0; c < 2; c++) begin
          r1[2*i+c] = al[i]; r2[2*i+c] = al[i]; db[2*i+c] = 1'b0; hist[2*i+c] = '0; ns[2*i+c] = 0;
        end
      end else begin
        l = db[2*i]; r = db[2*i+1];
        if (!l && !r) mode[i] = 0;
        else if (mode[i] == 3 || (l && r)) mode[i] = 3;
        else mode[i] = l ? 1 : 2;
        mask = (32'd1 << dms[i]) - 32'd1;
        for (int c = 0; c < 2; c++) begin
          p = r2[2*i+c] ^ al[i];
          hist[2*i+c] = {hist[2*i+c][30:0], p};
          ns[2*i+c]++;
          if (ns[2*i+c] >= dms[i] && (hist[2*i+c] & mask) == (db[2*i+c] ? 32'd0 : mask)) db[2*i+c] = p;
          r2[2*i+c] = r1[2*i+c];
          r1[2*i+c] = raw[2*i+c];
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("btn0", int'(b0), int'(mode[0] == 1));
    check("btn1_0", int'(b10), int'(mode[0] == 2));
    check("lock0", int'(lk0), int'(mode[0] == 3));
    check("excl0", int'(b0 & b10), 0);
    check("btn_c", int'(b1), int'(mode[1] == 1));
    check("btn1_c", int'(b11), int'(mode[1] == 2));
    check("lock_c", int'(lk1), int'(mode[1] == 3));
  endtask
  function automatic bit cur(input int sel);
    return (sel == 0) ? b0 : (sel == 1) ? b10 : lk0;
  endfunction
  task automatic wait_sig(input int sel, input bit lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cur(sel) != lvl && n < 60);
  endtask
  initial begin
    int n, seen, first, highs;
    rst = 1'b1; kl0 = 1'b0; kr0 = 1'b1; kl1 = 1'b0; kr1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    wait_sig(0, 1'b1, n);
    check("press_latency", n, 23);
    repeat (100 - n) tick();
    kl0 = 1'b1;
    wait_sig(0, 1'b0, n);
    check("release_latency", n, 23);
    seen = 0;
    kr0 = 1'b0; repeat (19) begin tick(); seen |= int'(b10); end
    kr0 = 1'b1; tick(); seen |= int'(b10);
    kr0 = 1'b0; repeat (19) begin tick(); seen |= int'(b10); end
    kr0 = 1'b1; repeat (25) begin tick(); seen |= int'(b10); end
    check("bounce", seen, 0);
    kr0 = 1'b0;
    wait_sig(1, 1'b1, n);
    check("bounce_latency", n, 23);
    repeat (5) tick();
    kr0 = 1'b1; kl0 = 1'b0;
    wait_sig(0, 1'b1, n);
    check("swap_latency", n, 23);
    check("swap_b1", int'(b10), 0);
    repeat (5) tick();
    kr0 = 1'b0;
    wait_sig(2, 1'b1, n);
    check("lock_latency", n, 23);
    check("lock_btn", int'(b0), 0);
    kl0 = 1'b1;
    repeat (40) tick();
    check("lock_hold", int'(lk0), 1);
    check("lock_b1", int'(b10), 0);
    kr0 = 1'b1;
    wait_sig(2, 1'b0, n);
    check("unlock_latency", n, 23);
    check("unlock_b0", int'(b0), 0);
    check("unlock_b1", int'(b10), 0);
    first = 0; highs = 0;
    kl1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) kl1 = 1'b0;
      tick();
      if (b1) begin
        highs++;
        if (first == 0) first = i;
      end
    end
    check("corner_latency", first, 4);
    check("corner_width", highs, 1);
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(499) == 0);
      if ($urandom_range(24) == 0) kl0 = ~kl0;
      if ($urandom_range(24) == 0) kr0 = ~kr0;
      if ($urandom_range(2) == 0) kl1 = ~kl1;
      if ($urandom_range(2) == 0) kr1 = ~kr1;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/player_buttons.md
# player_buttons

Input conditioner that drives the player's `button` / `button1` movement inputs from raw board push-buttons. It runs on the 1 ms game tick and performs four steps:
- synchronises each raw key;
- debounces it over a programmable number of ticks;
- arbitrates left/right so at most one movement request is active;
- presents clean, registered level signals to the player-position logic.

It sits between the board key pins and the player block in the game top level.

## Interface

Parameters
- `DEBOUNCE_MS`, default 20: consecutive ticks a key must hold a new level before it is accepted. Legal range 1..255.
- `ACTIVE_LOW`, default 1: 1 means raw keys read 0 when pressed; 0 means raw keys read 1 when pressed.

Ports
- `clk_1ms` input, 1 bit: 1 ms game tick. It is the only clock; all state is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `key_left` input, 1 bit: raw, asynchronous left push-button.
- `key_right` input, 1 bit: raw, asynchronous right push-button.
- `button` output, 1 bit: registered; 1 = move left this tick.
- `button1` output, 1 bit: registered; 1 = move right this tick.
- `locked` output, 1 bit: registered; 1 = both keys held, movement suppressed.

## Operation

- **Synchroniser**
  - Two-flop synchroniser per key.
  - Reset value is the raw "released" level: 1 if `ACTIVE_LOW`, else 0.
  - The second-stage output is normalised to `press_x` (1 = pressed) by inverting when `ACTIVE_LOW`.
- **Debounce**, per channel:
  - Registers: stable level `db_x` (reset 0) and counter `cnt_x`, 8 bits, reset 0.
  - If `press_x == db_x`: `cnt_x <= 0`.
  - Otherwise, if `cnt_x == DEBOUNCE_MS-1`: `db_x <= press_x` and `cnt_x <= 0`.
  - Otherwise: `cnt_x <= cnt_x + 1`.
  - A level change is therefore accepted only after exactly `DEBOUNCE_MS` consecutive differing samples. Any agreeing sample restarts the count.
  - Counter never exceeds `DEBOUNCE_MS-1`, so there is no wrap.
- **Arbitration FSM**: states IDLE, LEFT, RIGHT, LOCK; reset state IDLE. Transitions are evaluated on `db_l`, `db_r`:
  - **IDLE**:
    - `db_l & ~db_r` goes to LEFT.
    - `~db_l & db_r` goes to RIGHT.
    - `db_l & db_r` goes to LOCK.
    - Otherwise stay in IDLE.
  - **LEFT**:
    - `db_r` (with or without `db_l`) goes to LOCK if `db_l`, else to RIGHT.
    - `~db_l & ~db_r` goes to IDLE.
    - Otherwise stay in LEFT.
  - **RIGHT**: mirror of LEFT.
  - **LOCK**:
    - Only `~db_l & ~db_r` goes to IDLE.
    - Releasing one key does NOT resume movement; both must be released.
- **Outputs** are Moore outputs, registered alongside the state:
  - `button = (next state == LEFT)`
  - `button1 = (next state == RIGHT)`
  - `locked = (next state == LOCK)`
  - `button` and `button1` are never high together.
- **Reset mid-operation**: on the cycle `reset` is sampled high, all of the following are forced to their reset values, and all outputs are 0 after that edge, regardless of key state:
  - synchronisers
  - `db_x` and `cnt_x`
  - FSM state
  - outputs
- After reset is released, a key still held must re-qualify through the full debounce before any output asserts.

## Timing

- **Press latency**: raw key pressed before edge N, held stable, gives output asserted after edge N+`DEBOUNCE_MS`+2. That is `DEBOUNCE_MS`+3 ticks counting edge N as tick 1; 23 ticks with default parameters.
  - Stage breakdown: synchroniser 2 ticks, debounce `DEBOUNCE_MS` ticks, FSM 1 tick.
- **Release latency**: identical, `DEBOUNCE_MS`+3 ticks.
- **Glitch rejection**: any bounce shorter than `DEBOUNCE_MS` ticks produces no output change.
- **Direction swap**: LEFT to RIGHT is a direct transition. `button` falls and `button1` rises on the same edge, with no IDLE gap.
- **Simultaneous acceptance**: both `db` levels rising on the same edge goes to LOCK, never to LEFT or RIGHT.
- **`DEBOUNCE_MS = 1`**: a change is accepted on its first differing sample; latency is 4 ticks.

## Test plan

Defaults: `DEBOUNCE_MS = 20`, `ACTIVE_LOW = 1`.

- **Reset**: assert `reset` 3 ticks with `key_left = 0` (pressed) → `button`, `button1`, `locked` all 0 during reset. After release, `button` stays 0 for 22 ticks and rises on tick 23.
- **Clean press/release**: drive `key_left` low from tick 0 to tick 99, then high → `button` = 1 from tick 23 through tick 122, then 0. `button1` = 0 throughout.
- **Bounce rejection**: toggle `key_right` low for 19 ticks, high 1 tick, low 19 ticks, then high → `button1` never asserts. Then hold low 20 ticks → `button1` asserts 23 ticks after the final falling edge.
- **Direction swap**: with left held and `button` = 1, release left and press right on the same tick → within one tick `button` = 0 and `button1` = 1, 23 ticks later; never both 1.
- **Lock**:
  - Press right while left is active → `locked` = 1 and `button` = 0.
  - Release left only → still LOCK and `button1` = 0.
  - Release right → IDLE and all outputs 0 after 23 ticks.
- **Parameter corner**: `DEBOUNCE_MS = 1`, `ACTIVE_LOW = 0`; pulse `key_left` high for 1 tick → `button` high for exactly 1 tick, 4 ticks after the pulse.
